// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the ALU control decoder and the execute stage.
// Latency: none (wires only).
// Backpressure: busy from the slave tells the master that start is being ignored.
// Ports (slave view): start, alu_control, a, b in; result, zero, overflow, done, busy out.
interface alu_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             done;
  logic             busy;

  modport master (
    output start, alu_control, a, b,
    input  result, zero, overflow, done, busy
  );

  modport slave (
    input  start, alu_control, a, b,
    output result, zero, overflow, done, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: registered ALU result and flags; MUL is an iterative shift-add.
// Latency: 1 clock for single-cycle ops, WIDTH+1 clocks start->done for MUL.
// Backpressure: busy is high while a MUL iterates; start is ignored while busy.
// Ports: clk, rst_n (async, active-low), bus (slave): start/alu_control/a/b in,
//        result/zero/overflow/done/busy out.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic             overflow_q;
  logic             done_q;
  logic             busy_q;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    sum     = bus.a + bus.b;
    diff    = bus.a - bus.b;
    shamt   = bus.b[SHW-1:0];
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.alu_control)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: alu_res = bus.a << shamt;
      OP_SRL: alu_res = bus.a >> shamt;
      default: alu_res = '0;  // MUL is handled by the iterative path
    endcase
  end

  // Only the low WIDTH product bits are kept, so the multiplicand can shift
  // out of a WIDTH-bit register without losing anything that matters.
  always_comb begin
    acc_nxt = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_IDLE) begin
        if (bus.start) begin
          if (bus.alu_control == OP_MUL) begin
            mcand  <= bus.a;
            mplier <= bus.b;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_MUL;
          end else begin
            result_q   <= alu_res;
            overflow_q <= alu_ovf;
            done_q     <= 1'b1;
          end
        end
      end else begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        // Last iteration retires straight into the result register.
        if (cnt == SHW'(WIDTH - 1)) begin
          result_q   <= acc_nxt;
          overflow_q <= 1'b0;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state      <= ST_IDLE;
        end
      end
    end
  end

  assign bus.result   = result_q;
  assign bus.zero     = (result_q == '0);
  assign bus.overflow = overflow_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;

endmodule
